// File: rtl/taillight_pattern_decoder.sv
// Passive decoder for the taillight LED bus: classifies each side (OFF/ON/FLASH/SEQ),
// combines both sides into the controller's mode code and flags illegal lamp transitions.
module taillight_pattern_decoder #(
    parameter int unsigned HOLD_CYCLES = 5_000_000,
    parameter int unsigned HOLD_W      = 23,
    parameter int unsigned CONFIRM     = 2
) (
    input  logic       ADC_CLK_10,
    input  logic       rst,
    input  logic [9:0] led_in,
    output logic [2:0] mode,
    output logic       mode_valid,
    output logic       mode_change,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int unsigned RUN_W = $clog2(CONFIRM + 2);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(CONFIRM);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [2:0]        MODE_UNKNOWN = 3'd7;

    typedef enum logic [2:0] {
        CLS_UNK   = 3'd0,
        CLS_OFF   = 3'd1,
        CLS_ON    = 3'd2,
        CLS_FLASH = 3'd3,
        CLS_SEQ   = 3'd4
    } side_class_e;

    // Index 0 is the left side, index 1 the right side; values read outer to inner.
    logic [2:0]        side_s [2];
    logic [2:0]        prev_q [2];
    side_class_e       cls_q  [2];
    side_class_e       cls_d  [2];
    logic [RUN_W-1:0]  seq_q  [2];
    logic [RUN_W-1:0]  seq_d  [2];
    logic [RUN_W-1:0]  flash_q[2];
    logic [RUN_W-1:0]  flash_d[2];
    logic [HOLD_W-1:0] hold_q [2];
    logic [HOLD_W-1:0] hold_d [2];
    logic [1:0]        side_err_s;
    logic              unused_mid_s;

    logic [2:0] mode_q, mode_d;
    logic       mode_valid_q, mode_change_q, err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign side_s[0]    = {led_in[9], led_in[8], led_in[7]};
    assign side_s[1]    = {led_in[0], led_in[1], led_in[2]};
    assign unused_mid_s = ^led_in[6:3];

    // Per-side tracker: transition legality, run counters, hold timer, class.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            cls_d[s]      = cls_q[s];
            seq_d[s]      = seq_q[s];
            flash_d[s]    = flash_q[s];
            hold_d[s]     = hold_q[s];
            side_err_s[s] = 1'b0;
            if (side_s[s] != prev_q[s]) begin
                hold_d[s] = '0;
                case ({prev_q[s], side_s[s]})
                    6'b000_001, 6'b001_011, 6'b011_111: begin
                        seq_d[s]   = (seq_q[s] == RUN_MAX) ? seq_q[s] : seq_q[s] + RUN_W'(1);
                        flash_d[s] = '0;
                    end
                    6'b000_111: begin
                        flash_d[s] = (flash_q[s] == RUN_MAX) ? flash_q[s] : flash_q[s] + RUN_W'(1);
                        seq_d[s]   = '0;
                    end
                    6'b111_000: begin
                        seq_d[s]   = seq_q[s];
                        flash_d[s] = flash_q[s];
                    end
                    default: begin
                        side_err_s[s] = 1'b1;
                        seq_d[s]      = '0;
                        flash_d[s]    = '0;
                    end
                endcase
                if (side_err_s[s]) begin
                    cls_d[s] = CLS_UNK;
                end else if (seq_d[s] >= RUN_MAX) begin
                    cls_d[s] = CLS_SEQ;
                end else if (flash_d[s] >= RUN_MAX) begin
                    cls_d[s] = CLS_FLASH;
                end else begin
                    cls_d[s] = cls_q[s];
                end
            end else if (hold_q[s] != HOLD_MAX) begin
                hold_d[s] = hold_q[s] + HOLD_W'(1);
                // Steady value is judged only on the cycle the timer reaches its limit.
                if (hold_d[s] == HOLD_MAX) begin
                    if (side_s[s] == 3'b000) begin
                        cls_d[s]   = CLS_OFF;
                        seq_d[s]   = '0;
                        flash_d[s] = '0;
                    end else if (side_s[s] == 3'b111) begin
                        cls_d[s]   = CLS_ON;
                        seq_d[s]   = '0;
                        flash_d[s] = '0;
                    end else begin
                        cls_d[s]      = CLS_UNK;
                        side_err_s[s] = 1'b1;
                    end
                end else begin
                    cls_d[s] = cls_q[s];
                end
            end else begin
                hold_d[s] = hold_q[s];
            end
        end
    end

    // Combine the registered side classes into the controller mode code.
    always_comb begin
        mode_d = MODE_UNKNOWN;
        if (cls_q[0] == CLS_OFF && cls_q[1] == CLS_OFF) begin
            mode_d = 3'd0;
        end else if (cls_q[0] == CLS_FLASH && cls_q[1] == CLS_FLASH && prev_q[0] == prev_q[1]) begin
            mode_d = 3'd1;
        end else if (cls_q[0] == CLS_SEQ && cls_q[1] == CLS_OFF) begin
            mode_d = 3'd2;
        end else if (cls_q[0] == CLS_OFF && cls_q[1] == CLS_SEQ) begin
            mode_d = 3'd3;
        end else if (cls_q[0] == CLS_ON && cls_q[1] == CLS_ON) begin
            mode_d = 3'd4;
        end else if (cls_q[0] == CLS_SEQ && cls_q[1] == CLS_ON) begin
            mode_d = 3'd5;
        end else if (cls_q[0] == CLS_ON && cls_q[1] == CLS_SEQ) begin
            mode_d = 3'd6;
        end else begin
            mode_d = MODE_UNKNOWN;
        end
    end

    // Error pulse and saturating error counter; both sides failing together count once.
    always_comb begin
        err_d     = |side_err_s;
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers; reset re-seeds prev with the live bus to avoid a false edge.
    always_ff @(posedge ADC_CLK_10) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                prev_q[s]  <= side_s[s];
                cls_q[s]   <= CLS_UNK;
                seq_q[s]   <= '0;
                flash_q[s] <= '0;
                hold_q[s]  <= '0;
            end
            mode_q        <= MODE_UNKNOWN;
            mode_valid_q  <= 1'b0;
            mode_change_q <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                prev_q[s]  <= side_s[s];
                cls_q[s]   <= cls_d[s];
                seq_q[s]   <= seq_d[s];
                flash_q[s] <= flash_d[s];
                hold_q[s]  <= hold_d[s];
            end
            mode_q        <= mode_d;
            mode_valid_q  <= (mode_d != MODE_UNKNOWN);
            mode_change_q <= (mode_d != mode_q);
            err_q         <= err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign mode        = mode_q;
    assign mode_valid  = mode_valid_q;
    assign mode_change = mode_change_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_taillight_pattern_decoder.sv
// Directed bench for taillight_pattern_decoder with a short hold time (16 cycles) and CONFIRM=2.
module tb_taillight_pattern_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] led_in;
    logic [2:0] mode;
    logic       mode_valid;
    logic       mode_change;
    logic       err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    taillight_pattern_decoder #(
        .HOLD_CYCLES(16),
        .HOLD_W     (5),
        .CONFIRM    (2)
    ) dut (
        .ADC_CLK_10 (clk),
        .rst        (rst),
        .led_in     (led_in),
        .mode       (mode),
        .mode_valid (mode_valid),
        .mode_change(mode_change),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Build the bus from side values written outer-to-inner; middle lamps carry a fixed junk pattern.
    function automatic logic [9:0] mk(input logic [2:0] l, input logic [2:0] r);
        return {l[2], l[1], l[0], 4'b0101, r[0], r[1], r[2]};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [9:0] v);
        @(negedge clk);
        rst    = 1'b1;
        led_in = v;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int pulses;
        rst    = 1'b1;
        led_in = mk(3'b000, 3'b000);
        @(negedge clk);
        checks++; if (mode !== 3'd7) begin errors++; $display("FAIL rst_mode got=%0d exp=7", mode); end
        checks++; if (mode_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", mode_valid); end
        checks++; if (mode_change !== 1'b0) begin errors++; $display("FAIL rst_change got=%0b exp=0", mode_change); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_errcnt got=%0d exp=0", err_cnt); end
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mode_change === 1'b1) pulses++;
        end
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL idle_mode got=%0d exp=0", mode); end
        checks++; if (mode_valid !== 1'b1) begin errors++; $display("FAIL idle_valid got=%0b exp=1", mode_valid); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL idle_pulses got=%0d exp=1", pulses); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL idle_errcnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_seq_left();
        do_reset(mk(3'b000, 3'b000));
        cyc(20);
        led_in = mk(3'b001, 3'b000);
        cyc(8);
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL sigl_step1 got=%0d exp=0", mode); end
        led_in = mk(3'b011, 3'b000);
        cyc(1);
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL sigl_early got=%0d exp=0", mode); end
        cyc(1);
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL sigl_mode got=%0d exp=2", mode); end
        checks++; if (mode_change !== 1'b1) begin errors++; $display("FAIL sigl_change got=%0b exp=1", mode_change); end
        cyc(1);
        checks++; if (mode_change !== 1'b0) begin errors++; $display("FAIL sigl_change_end got=%0b exp=0", mode_change); end
        cyc(5);
        led_in = mk(3'b111, 3'b000);
        cyc(8);
        led_in = mk(3'b000, 3'b000);
        cyc(8);
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL sigl_wrap got=%0d exp=2", mode); end
        led_in = mk(3'b001, 3'b000);
        cyc(4);
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL sigl_stay got=%0d exp=2", mode); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL sigl_errcnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_flash();
        do_reset(mk(3'b000, 3'b000));
        cyc(20);
        led_in = mk(3'b111, 3'b111);
        cyc(8);
        led_in = mk(3'b000, 3'b000);
        cyc(8);
        led_in = mk(3'b111, 3'b111);
        cyc(2);
        checks++; if (mode !== 3'd1) begin errors++; $display("FAIL hzrd_mode got=%0d exp=1", mode); end
        checks++; if (mode_valid !== 1'b1) begin errors++; $display("FAIL hzrd_valid got=%0b exp=1", mode_valid); end
        cyc(6);
        led_in = mk(3'b000, 3'b111);
        cyc(2);
        checks++; if (mode !== 3'd7) begin errors++; $display("FAIL hzrd_skew got=%0d exp=7", mode); end
        checks++; if (mode_valid !== 1'b0) begin errors++; $display("FAIL hzrd_skew_valid got=%0b exp=0", mode_valid); end
        cyc(2);
        led_in = mk(3'b000, 3'b000);
        cyc(2);
        checks++; if (mode !== 3'd1) begin errors++; $display("FAIL hzrd_realign got=%0d exp=1", mode); end
        cyc(2);
        led_in = mk(3'b111, 3'b000);
        cyc(2);
        checks++; if (mode !== 3'd7) begin errors++; $display("FAIL hzrd_skew2 got=%0d exp=7", mode); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL hzrd_errcnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_brake();
        do_reset(mk(3'b111, 3'b111));
        cyc(16);
        checks++; if (mode !== 3'd7) begin errors++; $display("FAIL brk_early got=%0d exp=7", mode); end
        cyc(1);
        checks++; if (mode !== 3'd4) begin errors++; $display("FAIL brk_mode got=%0d exp=4", mode); end
        led_in = mk(3'b111, 3'b000);
        cyc(8);
        led_in = mk(3'b111, 3'b001);
        cyc(8);
        checks++; if (mode !== 3'd4) begin errors++; $display("FAIL brk_hold got=%0d exp=4", mode); end
        led_in = mk(3'b111, 3'b011);
        cyc(2);
        checks++; if (mode !== 3'd6) begin errors++; $display("FAIL brksigr_mode got=%0d exp=6", mode); end
        checks++; if (mode_valid !== 1'b1) begin errors++; $display("FAIL brksigr_valid got=%0b exp=1", mode_valid); end
    endtask

    task automatic test_illegal();
        do_reset(mk(3'b000, 3'b000));
        cyc(20);
        led_in = mk(3'b001, 3'b000);
        cyc(3);
        led_in = mk(3'b111, 3'b000);
        cyc(1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err got=%0b exp=1", err); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL ill_errcnt got=%0d exp=1", err_cnt); end
        cyc(1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_err_end got=%0b exp=0", err); end
        checks++; if (mode !== 3'd7) begin errors++; $display("FAIL ill_mode got=%0d exp=7", mode); end
        for (int i = 0; i < 299; i++) begin
            led_in = (i % 2 == 0) ? mk(3'b001, 3'b000) : mk(3'b111, 3'b000);
            cyc(1);
            if (i == 252) begin
                checks++; if (err_cnt !== 8'd254) begin errors++; $display("FAIL ill_cnt254 got=%0d exp=254", err_cnt); end
            end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err_sat got=%0b exp=1", err); end
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL ill_sat got=%0d exp=255", err_cnt); end
        cyc(3);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL ill_sat_hold got=%0d exp=255", err_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset(mk(3'b000, 3'b000));
        cyc(20);
        led_in = mk(3'b000, 3'b011);
        cyc(2);
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL mid_pre_errcnt got=%0d exp=1", err_cnt); end
        led_in = mk(3'b000, 3'b111);
        cyc(18);
        led_in = mk(3'b001, 3'b111);
        cyc(8);
        led_in = mk(3'b011, 3'b111);
        cyc(3);
        checks++; if (mode !== 3'd5) begin errors++; $display("FAIL brksigl_mode got=%0d exp=5", mode); end
        rst = 1'b1;
        cyc(1);
        checks++; if (mode !== 3'd7) begin errors++; $display("FAIL mid_mode got=%0d exp=7", mode); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_errcnt got=%0d exp=0", err_cnt); end
        checks++; if (mode_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%0b exp=0", mode_valid); end
        rst    = 1'b0;
        led_in = mk(3'b111, 3'b111);
        cyc(19);
        checks++; if (mode !== 3'd4) begin errors++; $display("FAIL mid_redecode got=%0d exp=4", mode); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_post_errcnt got=%0d exp=0", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_seq_left();
        test_flash();
        test_brake();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
